// File: rtl/shower_tx.sv
// Holds, upgrades and rate-limits the per-BX shower code to the TMB, with saturating per-level counters.
// 1-clk latency, no backpressure; the SHOWER_TX_INJECT_EN macro adds the inj_req/inj_code injection port.
module shower_tx #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       shower_int,
  input  logic             trig_stop,
  input  logic [2:0]       hold_len,
  input  logic [3:0]       dead_len,
  input  logic             cnt_clr,
  input  logic [1:0]       cnt_sel,
`ifdef SHOWER_TX_INJECT_EN
  input  logic             inj_req,
  input  logic [1:0]       inj_code,
`endif
  output logic [CNT_W-1:0] cnt_out,
  output logic [1:0]       shower_out,
  output logic             busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [1:0]       code, code_nxt;
  logic [2:0]       hold_cnt, hold_cnt_nxt;
  logic [3:0]       dead_cnt, dead_cnt_nxt;
  logic             trig_vld;
  logic [1:0]       trig_code;
  logic [3:0]       inc;
  logic [CNT_W-1:0] cnt [4];

  // Injection bypasses trig_stop and wins over the detector code.
  always_comb begin
    trig_vld  = (shower_int != 2'd0) && !trig_stop;
    trig_code = shower_int;
`ifdef SHOWER_TX_INJECT_EN
    if (inj_req && (inj_code != 2'd0)) begin
      trig_vld  = 1'b1;
      trig_code = inj_code;
    end
`endif
  end

  always_comb begin
    state_nxt    = state;
    code_nxt     = code;
    hold_cnt_nxt = hold_cnt;
    dead_cnt_nxt = dead_cnt;
    inc          = 4'd0;
    case (state)
      ST_IDLE: begin
        if (trig_vld) begin
          state_nxt      = ST_HOLD;
          code_nxt       = trig_code;
          hold_cnt_nxt   = hold_len;
          inc[0]         = 1'b1;
          inc[trig_code] = 1'b1;
        end
      end
      ST_HOLD: begin
        if (trig_stop) begin
          state_nxt    = ST_IDLE;
          hold_cnt_nxt = 3'd0;
          dead_cnt_nxt = 4'd0;
        end else begin
          if (shower_int > code) begin
            code_nxt        = shower_int;
            inc[shower_int] = 1'b1;
          end
          if (hold_cnt == 3'd0) begin
            if (dead_len != 4'd0) begin
              state_nxt    = ST_DEAD;
              dead_cnt_nxt = dead_len - 4'd1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            hold_cnt_nxt = hold_cnt - 3'd1;
          end
        end
      end
      ST_DEAD: begin
        if (trig_stop || (dead_cnt == 4'd0)) begin
          state_nxt    = ST_IDLE;
          dead_cnt_nxt = 4'd0;
        end else begin
          dead_cnt_nxt = dead_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_cnt_nxt = 3'd0;
        dead_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      code       <= 2'd0;
      hold_cnt   <= 3'd0;
      dead_cnt   <= 4'd0;
      shower_out <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      hold_cnt   <= hold_cnt_nxt;
      dead_cnt   <= dead_cnt_nxt;
      // Outputs are registered from the next-state view so they line up with the state they describe.
      shower_out <= (state_nxt == ST_HOLD) ? code_nxt : 2'd0;
      busy       <= (state_nxt != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      cnt_out <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (cnt_clr)
          cnt[i] <= '0;
        else if (inc[i] && (cnt[i] != {CNT_W{1'b1}}))
          cnt[i] <= cnt[i] + 1'b1;
      end
      cnt_out <= cnt[cnt_sel];
    end
  end

endmodule

// File: tb/tb_shower_tx.sv
// Randomized bench for shower_tx against a window-timestamp reference model.
module tb_shower_tx;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic [1:0]    shower_int;
  logic          trig_stop;
  logic [2:0]    hold_len;
  logic [3:0]    dead_len;
  logic          cnt_clr;
  logic [1:0]    cnt_sel;
  logic [CW-1:0] cnt_out;
  logic [1:0]    shower_out;
  logic          busy;

  int checks;
  int failures;

  // Reference model: absolute edge numbers bounding the hold and dead windows.
  int ecnt;
  int hold_hi;
  int dead_hi;
  int mcode;
  int mc [4];
  int exp_out;
  int exp_busy;
  int exp_cnt;

  shower_tx #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .shower_int (shower_int),
    .trig_stop  (trig_stop),
    .hold_len   (hold_len),
    .dead_len   (dead_len),
    .cnt_clr    (cnt_clr),
    .cnt_sel    (cnt_sel),
`ifdef SHOWER_TX_INJECT_EN
    .inj_req    (1'b0),
    .inj_code   (2'd0),
`endif
    .cnt_out    (cnt_out),
    .shower_out (shower_out),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    hold_hi  = -100;
    dead_hi  = -100;
    mcode    = 0;
    for (int i = 0; i < 4; i++) mc[i] = 0;
    exp_out  = 0;
    exp_busy = 0;
    exp_cnt  = 0;
  endtask

  task automatic model_step();
    int prev;
    int bump [4];
    prev = ecnt - 1;
    for (int i = 0; i < 4; i++) bump[i] = 0;
    exp_cnt = mc[cnt_sel];
    if (prev <= hold_hi) begin
      if (trig_stop) begin
        hold_hi = prev;
        dead_hi = prev;
      end else if (int'(shower_int) > mcode) begin
        mcode = int'(shower_int);
        bump[mcode] = 1;
      end
    end else if (prev <= dead_hi) begin
      if (trig_stop) dead_hi = prev;
    end else if (shower_int != 2'd0 && !trig_stop) begin
      mcode   = int'(shower_int);
      hold_hi = ecnt + int'(hold_len);
      dead_hi = hold_hi + int'(dead_len);
      bump[0] = 1;
      bump[mcode] = 1;
    end
    for (int i = 0; i < 4; i++) begin
      if (cnt_clr) mc[i] = 0;
      else if (bump[i] != 0 && mc[i] < CMAX) mc[i] = mc[i] + 1;
    end
    exp_out  = (ecnt <= hold_hi) ? mcode : 0;
    exp_busy = (ecnt <= dead_hi) ? 1 : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    ecnt++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; shower_int = 2'd0; trig_stop = 1'b0; hold_len = 3'd0; dead_len = 4'd0;
    cnt_clr = 1'b0; cnt_sel = 2'd0; ecnt = 0;
    model_reset();
    tick(); tick();
    checks++;
    if (shower_out !== 2'd0 || busy !== 1'b0 || cnt_out !== '0) begin
      failures++;
      $display("FAIL reset out=%0d busy=%0d cnt=%0d required 0/0/0", shower_out, busy, cnt_out);
    end
    #3 rst_n = 1'b1;
    tick();
    checks++;
    if (shower_out !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release out=%0d busy=%0d required 0/0", shower_out, busy);
    end
  endtask

  task automatic test_basic_hold();
    int seq_out [7] = '{2, 2, 2, 0, 0, 0, 0};
    int seq_bsy [7] = '{1, 1, 1, 1, 1, 1, 0};
    hold_len = 3'd2; dead_len = 4'd3;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    shower_int = 2'd2;
    for (int i = 0; i < 7; i++) begin
      tick();
      shower_int = 2'd0;
      checks++;
      if (shower_out !== 2'(seq_out[i]) || busy !== 1'(seq_bsy[i]) ||
          shower_out !== 2'(exp_out) || busy !== 1'(exp_busy)) begin
        failures++;
        $display("FAIL basic_hold i=%0d out=%0d busy=%0d required %0d/%0d", i, shower_out, busy, seq_out[i], seq_bsy[i]);
      end
    end
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      tick();
      checks++;
      if (cnt_out !== CW'(exp_cnt) || cnt_out !== CW'((s == 0 || s == 2) ? 1 : 0)) begin
        failures++;
        $display("FAIL basic_cnt sel=%0d cnt=%0d required %0d", s, cnt_out, exp_cnt);
      end
    end
  endtask

  task automatic test_upgrade();
    int stim [8] = '{1, 0, 3, 2, 0, 0, 0, 0};
    int seq  [8] = '{1, 1, 3, 3, 3, 0, 0, 0};
    hold_len = 3'd4; dead_len = 4'd2;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      shower_int = 2'(stim[i]);
      tick();
      checks++;
      if (shower_out !== 2'(seq[i]) || shower_out !== 2'(exp_out) || busy !== 1'(exp_busy)) begin
        failures++;
        $display("FAIL upgrade i=%0d out=%0d busy=%0d required %0d/%0d", i, shower_out, busy, seq[i], exp_busy);
      end
    end
    shower_int = 2'd0;
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      tick();
      checks++;
      if (cnt_out !== CW'(exp_cnt) || cnt_out !== CW'((s == 2) ? 0 : 1)) begin
        failures++;
        $display("FAIL upgrade_cnt sel=%0d cnt=%0d required %0d", s, cnt_out, exp_cnt);
      end
    end
  endtask

  task automatic test_dead_block();
    int rises;
    int prev_out;
    hold_len = 3'($urandom_range(0, 7)); dead_len = 4'd5;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    cnt_sel = 2'd0; shower_int = 2'd3; rises = 0; prev_out = 0;
    for (int i = 0; i < 3 * (int'(hold_len) + 7); i++) begin
      tick();
      if (shower_out != 2'd0 && prev_out == 0) rises++;
      prev_out = int'(shower_out);
      checks++;
      if (shower_out !== 2'(exp_out) || busy !== 1'(exp_busy) || cnt_out !== CW'(exp_cnt)) begin
        failures++;
        $display("FAIL dead_block i=%0d out=%0d busy=%0d cnt=%0d required %0d/%0d/%0d",
                 i, shower_out, busy, cnt_out, exp_out, exp_busy, exp_cnt);
      end
    end
    checks++;
    if (rises != 3) begin
      failures++;
      $display("FAIL dead_block_period triggers=%0d required 3", rises);
    end
    shower_int = 2'd0; trig_stop = 1'b1; tick(); trig_stop = 1'b0;
  endtask

  task automatic test_trig_stop();
    hold_len = 3'd5; dead_len = 4'd4;
    trig_stop = 1'b1; shower_int = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (shower_out !== 2'd0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL stop_idle out=%0d busy=%0d required 0/0", shower_out, busy);
      end
    end
    trig_stop = 1'b0; shower_int = 2'd1;
    tick(); shower_int = 2'd0;
    tick();
    trig_stop = 1'b1;
    tick();
    checks++;
    if (shower_out !== 2'd0 || busy !== 1'b0 || exp_busy != 0) begin
      failures++;
      $display("FAIL stop_abort out=%0d busy=%0d required 0/0", shower_out, busy);
    end
    trig_stop = 1'b0; shower_int = 2'd2;
    tick(); shower_int = 2'd0;
    checks++;
    if (shower_out !== 2'd2 || busy !== 1'b1 || shower_out !== 2'(exp_out)) begin
      failures++;
      $display("FAIL stop_retrigger out=%0d busy=%0d required 2/1", shower_out, busy);
    end
    trig_stop = 1'b1; tick(); trig_stop = 1'b0;
  endtask

  task automatic test_saturation();
    hold_len = 3'd0; dead_len = 4'd0; cnt_sel = 2'd1;
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    shower_int = 2'd1;
    for (int i = 0; i < 2 * (CMAX + 3); i++) tick();
    shower_int = 2'd0;
    tick(); tick();
    checks++;
    if (cnt_out !== CW'(CMAX) || cnt_out !== CW'(exp_cnt)) begin
      failures++;
      $display("FAIL saturate cnt=%0d required %0d", cnt_out, CMAX);
    end
    shower_int = 2'd3; cnt_clr = 1'b1;
    tick();
    shower_int = 2'd0; cnt_clr = 1'b0;
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      tick();
      checks++;
      if (s > 0 && (cnt_out !== '0 || cnt_out !== CW'(exp_cnt))) begin
        failures++;
        $display("FAIL clear_with_trig sel=%0d cnt=%0d required 0", s, cnt_out);
      end
    end
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 10; blk++) begin
      hold_len = 3'($urandom_range(0, 7));
      dead_len = 4'($urandom_range(0, 15));
      for (int i = 0; i < 150; i++) begin
        shower_int = ($urandom_range(0, 1) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
        trig_stop  = ($urandom_range(0, 19) == 0);
        cnt_clr    = ($urandom_range(0, 59) == 0);
        cnt_sel    = 2'($urandom_range(0, 3));
        tick();
        checks++;
        if (shower_out !== 2'(exp_out) || busy !== 1'(exp_busy) || cnt_out !== CW'(exp_cnt)) begin
          failures++;
          $display("FAIL random blk=%0d i=%0d out=%0d busy=%0d cnt=%0d required %0d/%0d/%0d",
                   blk, i, shower_out, busy, cnt_out, exp_out, exp_busy, exp_cnt);
        end
      end
      shower_int = 2'd0; cnt_clr = 1'b0; trig_stop = 1'b1;
      tick();
      trig_stop = 1'b0;
    end
  endtask

  task automatic test_async_reset();
    hold_len = 3'd6; dead_len = 4'd2; cnt_sel = 2'd0;
    shower_int = 2'd2;
    tick(); shower_int = 2'd0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (shower_out !== 2'd0 || busy !== 1'b0 || cnt_out !== '0) begin
      failures++;
      $display("FAIL async_reset out=%0d busy=%0d cnt=%0d required 0/0/0", shower_out, busy, cnt_out);
    end
    tick(); tick();
    #2 rst_n = 1'b1;
    hold_len = 3'd1; dead_len = 4'd0;
    shower_int = 2'd1;
    tick(); shower_int = 2'd0;
    checks++;
    if (shower_out !== 2'd1 || busy !== 1'b1 || shower_out !== 2'(exp_out)) begin
      failures++;
      $display("FAIL reset_retrigger out=%0d busy=%0d required 1/1", shower_out, busy);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic_hold();
    test_upgrade();
    test_dead_block();
    test_trig_stop();
    test_saturation();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shower_tx.md
# shower_tx

Output-side companion to the anode shower detector. It takes the per-BX 2-bit shower code (0 none, 1 loose, 2 nominal, 3 tight) and turns it into a stable, rate-limited code on the link to the TMB. The code is held for a programmable number of BX, upgraded when a stronger shower arrives during the hold, and followed by a programmable dead time. The block also keeps saturating per-level counters for slow-control readout. It sits between the shower detector output register and the TMB output multiplexer.

## Interface
Parameters:
- CNT_W, default 16, width of the per-level event counters.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  BX clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- shower_int  input  2  shower code from the detector, valid every clk.
- trig_stop  input  1  global trigger inhibit.
- hold_len  input  3  hold length minus one; the code is held hold_len+1 BX (1..8).
- dead_len  input  4  dead time in BX after the hold (0..15; 0 means no dead time).
- cnt_clr  input  1  synchronous clear of all counters.
- cnt_sel  input  2  counter select: 0 total, 1 loose, 2 nominal, 3 tight.
- cnt_out  output  CNT_W  selected counter, registered.
- shower_out  output  2  held shower code to the TMB.
- busy  output  1  high in HOLD or DEAD.

## Operation
- The FSM has three states: IDLE, HOLD, DEAD. Reset state is IDLE. Reset values: shower_out=0, busy=0, cnt_out=0, all counters 0, hold/dead counters 0.
- IDLE:
  - Trigger condition: shower_int!=0 and trig_stop=0.
  - On trigger: latch code=shower_int, load hold_cnt=hold_len, go to HOLD.
  - Counting on trigger: increment the counter for that level and the total counter.
  - No trigger: stay in IDLE.
- HOLD:
  - shower_out=code.
  - Upgrade: if shower_int>code and trig_stop=0, set code=shower_int and increment the new level's counter. Total is not incremented, and hold_cnt is not reloaded. Lower or equal codes are ignored.
  - Exit: when hold_cnt==0, go to DEAD with dead_cnt=dead_len-1 if dead_len!=0, otherwise go to IDLE. Otherwise decrement hold_cnt.
- DEAD:
  - shower_out=0; shower_int is ignored.
  - When dead_cnt==0, go to IDLE; otherwise decrement dead_cnt.
  - A shower present on the cycle the FSM enters IDLE is not seen. Evaluation starts on the first cycle spent in IDLE.
- trig_stop=1 in HOLD or DEAD aborts to IDLE: shower_out=0 on the next clock and no dead time is applied. The counters are not affected.
- Counters:
  - Saturate at all-ones and never wrap.
  - cnt_clr has priority over any increment in the same cycle.
  - cnt_out = mux(cnt_sel) registered, one clock latency.
- Reset asserted mid-operation drops all outputs to zero immediately, asynchronously.

## Timing
- shower_out follows a triggering shower_int by 1 clk (registered).
- Upgrades appear on shower_out 1 clk after the stronger shower_int.
- A trigger at cycle T with hold_len=H and dead_len=D:
  - shower_out!=0 for cycles T+1..T+H+1.
  - shower_out is 0 (dead) for T+H+2..T+H+D+1.
  - The earliest new trigger sample is T+H+D+2; its output appears at T+H+D+3.
- With D=0, the earliest re-trigger sample is T+H+2, giving an output gap of one BX.
- busy is registered and coincident with the HOLD/DEAD state of the output cycle.
- cnt_out reflects counter state from the previous clk.

## Configuration
- SHOWER_TX_INJECT_EN defined:
  - Adds inputs inj_req (1) and inj_code (2).
  - In IDLE, inj_req=1 with inj_code!=0 triggers exactly like shower_int=inj_code, regardless of trig_stop.
  - inj_req has priority over shower_int in the same cycle.
  - Injected triggers increment the counters.
  - In HOLD/DEAD, inj_req is ignored.
- Not defined: the ports and logic are absent; behaviour is as above with injection impossible.

## Test plan
- Basic hold: hold_len=2, dead_len=3, shower_int=2 for one clk at T. Expected: shower_out=2 at T+1..T+3, 0 at T+4..T+6; total=1, nominal=1.
- Upgrade: hold_len=4, shower_int=1 at T, then 3 at T+2, then 2 at T+3. Expected: shower_out=1 at T+1..T+2, 3 at T+3..T+5; loose=1, tight=1, total=1.
- Dead-time blocking: dead_len=5, shower_int=3 continuously. Expected: a period of hold_len+dead_len+2 BX; total increments once per period.
- trig_stop: trig_stop=1 with shower_int=3 in IDLE gives no output. trig_stop raised at the second HOLD cycle gives shower_out=0 on the next clk and busy=0, after which a re-trigger is accepted immediately.
- Counter saturation and clear:
  - Preload by forcing loose near 0xFFFE; two triggers leave it at 0xFFFF.
  - cnt_clr coincident with a trigger leaves all counters 0.
  - cnt_sel=1 shows the value one clk later.
- Async reset mid-HOLD: rst_n low asynchronously forces shower_out=0, busy=0 and cnt_out=0. After release, the FSM is in IDLE and the first shower_int=1 produces shower_out=1 one clk later.
